// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with optional write bypass,
// hardwired zero register and a per-register busy scoreboard.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        i_rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic [NUM_RD-1:0]        o_rd_valid,
    output logic [NUM_RD-1:0]        o_rd_busy,
    input  logic                     i_wr_en,
    input  logic [ADDR_W-1:0]        i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_rsv_en,
    input  logic [ADDR_W-1:0]        i_rsv_addr,
    output logic [ADDR_W:0]          o_busy_cnt
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    // an address is live when in range and not the hardwired zero register
    function automatic logic f_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_L) && !(ZERO_REG != 0 && a == '0);
    endfunction

    logic [DATA_W-1:0]        r_mem [DEPTH];
    logic [DEPTH-1:0]         r_busy;
    logic [DEPTH-1:0]         w_busy_nxt;
    logic                     w_wr_ok;
    logic                     w_rsv_ok;
    logic [ADDR_W:0]          w_cnt;
    logic [NUM_RD*DATA_W-1:0] w_rd_data;
    logic [NUM_RD-1:0]        w_rd_busy;

    assign w_wr_ok  = i_wr_en && f_ok(i_wr_addr);
    assign w_rsv_ok = i_rsv_en && f_ok(i_rsv_addr);

    // reserve is applied after release so a same-cycle reserve wins
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_ok) w_busy_nxt[i_wr_addr] = 1'b0;
        if (w_rsv_ok) w_busy_nxt[i_rsv_addr] = 1'b1;
        w_cnt = '0;
        for (int j = 0; j < DEPTH; j++) w_cnt += (ADDR_W+1)'(w_busy_nxt[j]);
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (f_ok(i_rd_addr[p*ADDR_W +: ADDR_W])) begin
                w_rd_data[p*DATA_W +: DATA_W] =
                    (BYPASS != 0 && w_wr_ok && i_wr_addr == i_rd_addr[p*ADDR_W +: ADDR_W])
                    ? i_wr_data : r_mem[i_rd_addr[p*ADDR_W +: ADDR_W]];
                w_rd_busy[p] = BYPASS != 0 ? w_busy_nxt[i_rd_addr[p*ADDR_W +: ADDR_W]]
                                           : r_busy[i_rd_addr[p*ADDR_W +: ADDR_W]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) r_mem[j] <= '0;
            r_busy     <= '0;
            o_rd_data  <= '0;
            o_rd_valid <= '0;
            o_rd_busy  <= '0;
            o_busy_cnt <= '0;
        end else begin
            if (w_wr_ok) r_mem[i_wr_addr] <= i_wr_data;
            r_busy     <= w_busy_nxt;
            o_busy_cnt <= w_cnt;
            o_rd_valid <= i_rd_en;
            for (int p = 0; p < NUM_RD; p++) begin
                if (i_rd_en[p]) begin
                    o_rd_data[p*DATA_W +: DATA_W] <= w_rd_data[p*DATA_W +: DATA_W];
                    o_rd_busy[p]                  <= w_rd_busy[p];
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp (DEPTH=24, three read ports, bypass on).
module tb_regfile_mp;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [2:0]  rd_en = 0;
    logic [14:0] rd_addr = 0;
    logic [95:0] rd_data;
    logic [2:0]  rd_valid, rd_busy;
    logic        wr_en = 0;
    logic [4:0]  wr_addr = 0;
    logic [31:0] wr_data = 0;
    logic        rsv_en = 0;
    logic [4:0]  rsv_addr = 0;
    logic [5:0]  busy_cnt;

    regfile_mp #(.DATA_W(32), .DEPTH(24), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
        .o_rd_valid(rd_valid), .o_rd_busy(rd_busy), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr), .o_busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  en;
        logic [2:0]  b;
        logic [95:0] d;
        logic [5:0]  cnt;
    } exp_t;

    exp_t        q[$];
    int          total = 0, bad = 0;
    bit          run = 0;
    logic [31:0] mem [32];
    bit   [31:0] mb;
    logic [95:0] ld;
    logic [2:0]  lb;

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic bit ok(input logic [4:0] a);
        return a < 24 && a != 0;
    endfunction

    function automatic logic [14:0] pk(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        return {a2, a1, a0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem[i] = 0;
        mb = 0; ld = 0; lb = 0;
    endtask

    // one clock of stimulus; expected outputs after the following edge go to the queue
    task automatic step(input logic [2:0] en, input logic [14:0] ra, input bit we, input logic [4:0] wa,
                        input logic [31:0] wd, input bit rv, input logic [4:0] sa);
        exp_t e;
        bit [31:0] nb;
        bit wok, sok;
        logic [4:0] a;
        @(negedge clk);
        rd_en = en; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd; rsv_en = rv; rsv_addr = sa;
        wok = we && ok(wa);
        sok = rv && ok(sa);
        nb = mb;
        if (wok) nb[wa] = 0;
        if (sok) nb[sa] = 1;
        for (int p = 0; p < 3; p++) begin
            a = ra[p*5 +: 5];
            if (en[p]) begin
                ld[p*32 +: 32] = !ok(a) ? 32'h0 : (wok && wa == a) ? wd : mem[a];
                lb[p] = ok(a) && nb[a];
            end
        end
        if (wok) mem[wa] = wd;
        mb = nb;
        e.en = en; e.b = lb; e.d = ld; e.cnt = 6'($countones(mb));
        q.push_back(e);
        run = 1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic peek();
        @(posedge clk);
        #2;
    endtask

    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (run) begin
            if (q.size() == 0) begin
                chk("queue_underflow", 1, 0);
            end else begin
                e = q.pop_front();
                chk("rd_valid", rd_valid, e.en);
                chk("rd_data", rd_data, e.d);
                chk("rd_busy", rd_busy, e.b);
                chk("busy_cnt", busy_cnt, e.cnt);
            end
        end
    end

    initial begin
        model_reset();
        #3;
        chk("reset_data", rd_data, 0);
        chk("reset_valid", rd_valid, 0);
        chk("reset_cnt", busy_cnt, 0);
        @(negedge clk);
        rst_n = 1;
        // write then read on port 1 one cycle later
        step(0, 0, 1, 3, 32'h12345678, 0, 0);
        step(3'b010, pk(0, 3, 0), 0, 0, 0, 0, 0);
        peek();
        chk("lat_data1", rd_data[63:32], 32'h12345678);
        chk("lat_valid", rd_valid, 3'b010);
        idle();
        peek();
        chk("valid_one_cycle", rd_valid, 0);
        chk("hold_data1", rd_data[63:32], 32'h12345678);
        // same-cycle bypass on two ports
        step(3'b011, pk(9, 9, 0), 1, 9, 32'hA5A5A5A5, 0, 0);
        peek();
        chk("bypass_p0", rd_data[31:0], 32'hA5A5A5A5);
        chk("bypass_p1", rd_data[63:32], 32'hA5A5A5A5);
        // zero register ignores write and reserve
        step(3'b111, pk(0, 0, 0), 1, 0, 32'hFFFFFFFF, 1, 0);
        peek();
        chk("zero_data", rd_data, 0);
        chk("zero_busy", rd_busy, 0);
        chk("zero_cnt", busy_cnt, 0);
        // scoreboard reserve/release
        step(0, 0, 0, 0, 0, 1, 4);
        step(0, 0, 0, 0, 0, 1, 6);
        peek();
        chk("sb_cnt2", busy_cnt, 2);
        step(0, 0, 0, 0, 0, 1, 4);
        peek();
        chk("sb_rereserve", busy_cnt, 2);
        step(0, 0, 1, 4, 32'h44, 0, 0);
        peek();
        chk("sb_release", busy_cnt, 1);
        step(3'b100, pk(0, 0, 6), 1, 6, 32'h66, 1, 6);
        peek();
        chk("sb_wr_rsv_busy", rd_busy[2], 1);
        chk("sb_wr_rsv_data", rd_data[95:64], 32'h66);
        chk("sb_wr_rsv_cnt", busy_cnt, 1);
        // out-of-range address
        step(3'b001, pk(30, 0, 0), 1, 30, 32'h1, 1, 30);
        peek();
        chk("oor_data", rd_data[31:0], 0);
        chk("oor_busy", rd_busy[0], 0);
        chk("oor_valid", rd_valid[0], 1);
        for (int a = 1; a < 32; a++) step(0, 0, 0, 0, 0, 1, 5'(a));
        peek();
        chk("all_busy_cnt", busy_cnt, 23);
        // asynchronous reset mid-run
        step(0, 0, 1, 5, 32'hDEADBEEF, 1, 7);
        @(negedge clk);
        run = 0;
        rd_en = 0; wr_en = 0; rsv_en = 0;
        #2 rst_n = 0;
        #1;
        chk("async_rst_data", rd_data, 0);
        chk("async_rst_cnt", busy_cnt, 0);
        chk("async_rst_busy", rd_busy, 0);
        #1 rst_n = 1;
        model_reset();
        step(3'b001, pk(5, 0, 0), 0, 0, 0, 0, 0);
        peek();
        chk("post_rst_reg5", rd_data[31:0], 0);
        // randomized traffic, addresses biased towards a small set to force collisions
        for (int i = 0; i < 400; i++) begin
            logic [14:0] ra;
            for (int p = 0; p < 3; p++)
                ra[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            step(3'($urandom), ra, 1'($urandom), 5'($urandom_range(0, 9)), $urandom,
                 ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 9)));
        end
        idle();
        peek();
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
